key_note_encoder: RTL and testbench
===================================

Name: key_note_encoder

Overview:
- Front-end stage of the digital piano. Feeds the tone generator that sits downstream of it.
- Debounces seven raw note keys (scale degrees 1..7) and a 2-bit octave switch, all asynchronous inputs.
- Produces the 12-bit {high,med,low} note code that the tone generator already decodes, plus a held-level flag and a one-cycle new-note strobe.

Parameters:
DEBOUNCE_CYCLES, 100000, number of consecutive stable cycles required before accepting a change (20 ms at 5 MHz).
CNT_W, 17, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk_5MHz  in   1   system clock; the only clock.
rst       in   1   synchronous, active-high reset.
key_n     in   7   raw note keys, active-low. Bit i is scale degree i+1. Asynchronous.
oct_sel   in   2   raw octave switch: 00 low, 01 med, 10 high, 11 treated as med. Asynchronous.
note_code out  12  {high[11:8],med[7:4],low[3:0]}. The selected nibble holds the degree 1..7; the other nibbles are 0. All-zero means rest.
note_valid out 1   high while a debounced note is held.
note_strobe out 1  one-cycle pulse each time a new note is accepted.
key_idx   out  3   degree 1..7 of the accepted note; 0 when idle.

Behaviour:
- Reset (rst high at a clk_5MHz edge):
  - note_code=0, note_valid=0, note_strobe=0, key_idx=0.
  - State=IDLE, counter=0.
  - Synchronizer flops preset to key_n=7'h7F and oct_sel=01.
  - rst asserted mid-debounce or mid-note aborts immediately. There is no strobe on the way out or on the way back.
- Input path:
  - Two-flop synchronizer on each key_n and oct_sel bit.
  - Pressed vector p = ~key_n_sync.
  - Candidate cand = lowest set bit index of p, plus 1 (range 1..7). cand = 0 if no key is pressed.
  - cand is registered as cand_r.
- Debounce counter:
  - Cleared whenever cand != cand_r; otherwise increments.
  - Saturates at DEBOUNCE_CYCLES-1.
  - "Stable" means cand == cand_r and counter == DEBOUNCE_CYCLES-1.
- FSM states and transitions:
  - IDLE: note outputs at rest. On cand_r != 0, go to ARM.
  - ARM: if cand_r returns to 0 before stable, go to IDLE with no output change. If stable with cand_r != 0, accept the note and go to HELD.
  - HELD: outputs frozen. On cand_r != latched degree, go to LEAVE.
  - LEAVE: outputs still frozen.
    - cand_r returns to the latched degree before stable: go to HELD, no strobe.
    - Stable with cand_r = 0: release and go to IDLE.
    - Stable with cand_r = a new nonzero degree: accept it and go to HELD (legato change, strobe fires).
- Counter restart: any cand change in ARM or LEAVE clears the counter. Chattering therefore never produces a note.
- Accept action, registered in the same cycle:
  - key_idx = degree; note_valid = 1; note_strobe = 1 for exactly one cycle.
  - note_code = degree placed in the nibble chosen by the synchronized oct_sel at that cycle.
  - oct_sel changes while held have no effect until the next accept.
- Release action: note_code=0, key_idx=0, note_valid=0. No strobe.
- Latency: a clean raw press first sampled at edge N gives note_strobe high in cycle N+DEBOUNCE_CYCLES+3. Release has the same latency to note_valid=0.
- Simultaneous keys: the lowest degree wins. Pressing a higher key while a lower one is held causes no change. Releasing the lower key while the higher is still held yields a new accept of the higher degree.
- Width rule: note_code nibbles are 4 bits wide. Degree values never exceed 7.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then hold key_n=7'h7F and oct_sel=01 for 50 cycles -> all outputs 0, note_strobe never asserted.
2. oct_sel=01, key_n[2] low at edge 10 and held -> note_strobe high only in cycle 17; note_code=12'h030, key_idx=3, note_valid=1. Release at edge 40 -> note_code=0, note_valid=0 in cycle 47, no strobe.
3. key_n[4] toggles every 2 cycles for 40 cycles, oct_sel=10 -> no strobe, note_valid=0 throughout. Then hold it low -> note_code=12'h500, one strobe.
4. Hold degree 6 with oct_sel=00 (note_code=12'h006). Then also press degree 2 -> note_code=12'h002 with a second strobe. Release degree 2 with degree 6 still held -> note_code=12'h006 with a third strobe.
5. Hold degree 1 with oct_sel=01 (note_code=12'h010). Switch oct_sel to 10 while held -> note_code stays 12'h010. Release, then press degree 1 again -> note_code=12'h100. Also with oct_sel=11, press degree 5 -> note_code=12'h050.
6. Assert rst for 1 cycle during ARM and again during HELD -> outputs 0 the next cycle, no strobe. Re-acceptance takes the full debounce latency after rst drops.

Source files
------------

// File: rtl/key_note_encoder.sv
// Piano key front end: synchronizes and debounces seven note keys plus the octave
// switch, and emits the {high,med,low} note code consumed by the tone generator.
module key_note_encoder #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic        clk_5MHz,
  input  logic        rst,
  input  logic [6:0]  key_n,
  input  logic [1:0]  oct_sel,
  output logic [11:0] note_code,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [2:0]  key_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, HELD, LEAVE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  key_meta, key_sync;
  logic [1:0]  oct_meta, oct_sync;
  logic [2:0]  cand, cand_r;
  logic [CNT_W-1:0] cnt;
  logic        stable;
  logic [11:0] code_nxt, accept_code;
  logic        valid_nxt, strobe_nxt;
  logic [2:0]  idx_nxt;

  // Lowest pressed degree wins; 0 means no key down.
  always_comb begin
    cand = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (!key_sync[i]) cand = 3'(i + 1);
    end
  end

  assign stable = (cand == cand_r) && (cnt == CNT_MAX);

  always_comb begin
    accept_code = 12'h000;
    case (oct_sync)
      2'b00:   accept_code = {8'h00, 1'b0, cand_r};
      2'b10:   accept_code = {1'b0, cand_r, 8'h00};
      default: accept_code = {4'h0, 1'b0, cand_r, 4'h0};
    endcase
  end

  always_ff @(posedge clk_5MHz) begin
    if (rst) begin
      key_meta    <= 7'h7F;
      key_sync    <= 7'h7F;
      oct_meta    <= 2'b01;
      oct_sync    <= 2'b01;
      cand_r      <= 3'd0;
      cnt         <= '0;
      state       <= IDLE;
      note_code   <= 12'h000;
      note_valid  <= 1'b0;
      note_strobe <= 1'b0;
      key_idx     <= 3'd0;
    end else begin
      key_meta    <= key_n;
      key_sync    <= key_meta;
      oct_meta    <= oct_sel;
      oct_sync    <= oct_meta;
      cand_r      <= cand;
      if (cand != cand_r)   cnt <= '0;
      else if (!stable)     cnt <= cnt + CNT_W'(1);
      state       <= state_nxt;
      note_code   <= code_nxt;
      note_valid  <= valid_nxt;
      note_strobe <= strobe_nxt;
      key_idx     <= idx_nxt;
    end
  end

  // key_idx doubles as the latched degree that HELD/LEAVE compare against.
  always_comb begin
    state_nxt  = state;
    code_nxt   = note_code;
    valid_nxt  = note_valid;
    idx_nxt    = key_idx;
    strobe_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (cand_r != 3'd0) state_nxt = ARM;
      end
      ARM: begin
        if (cand_r == 3'd0) begin
          state_nxt = IDLE;
        end else if (stable) begin
          state_nxt  = HELD;
          code_nxt   = accept_code;
          valid_nxt  = 1'b1;
          idx_nxt    = cand_r;
          strobe_nxt = 1'b1;
        end
      end
      HELD: begin
        if (cand_r != key_idx) state_nxt = LEAVE;
      end
      LEAVE: begin
        if (cand_r == key_idx) begin
          state_nxt = HELD;
        end else if (stable && cand_r == 3'd0) begin
          state_nxt = IDLE;
          code_nxt  = 12'h000;
          valid_nxt = 1'b0;
          idx_nxt   = 3'd0;
        end else if (stable) begin
          state_nxt  = HELD;
          code_nxt   = accept_code;
          valid_nxt  = 1'b1;
          idx_nxt    = cand_r;
          strobe_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_note_encoder.sv
// Directed bench for key_note_encoder with a short debounce window.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_key_note_encoder;

  localparam int DC = 4;

  logic        clk_5MHz = 1'b0;
  logic        rst;
  logic [6:0]  key_n;
  logic [1:0]  oct_sel;
  logic [11:0] note_code;
  logic        note_valid;
  logic        note_strobe;
  logic [2:0]  key_idx;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [6:0]  key;
    logic [1:0]  oct;
    int          cycles;
    logic [11:0] code;
    logic        valid;
    logic [2:0]  idx;
    int          strobes;
  } vec_t;

  vec_t vecs [13];

  key_note_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk_5MHz   (clk_5MHz),
    .rst        (rst),
    .key_n      (key_n),
    .oct_sel    (oct_sel),
    .note_code  (note_code),
    .note_valid (note_valid),
    .note_strobe(note_strobe),
    .key_idx    (key_idx)
  );

  always #100 clk_5MHz = ~clk_5MHz;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sample j is taken just after the j-th rising edge following the input change,
  // so a strobe registered at edge N+DC+2 shows up as sample DC+3.
  task automatic applyStimulus(input logic [6:0] k, input logic [1:0] o, input int cycles,
                               output int strobes, output int first_strobe,
                               output int first_low, output int valid_seen);
    key_n = k;
    oct_sel = o;
    strobes = 0;
    first_strobe = 0;
    first_low = 0;
    valid_seen = 0;
    for (int j = 1; j <= cycles; j++) begin
      @(negedge clk_5MHz);
      if (note_strobe) begin
        strobes++;
        if (first_strobe == 0) first_strobe = j;
      end
      if (!note_valid && first_low == 0) first_low = j;
      if (note_valid) valid_seen = 1;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " code"},   int'(note_code),   0);
    checkOutput({tag, " valid"},  int'(note_valid),  0);
    checkOutput({tag, " strobe"}, int'(note_strobe), 0);
    checkOutput({tag, " idx"},    int'(key_idx),     0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk_5MHz);
    rst = 1'b0;
  endtask

  initial begin
    int s, fs, fl, vs, ts, tv;

    vecs[0]  = '{7'h7F, 2'b01, 50, 12'h000, 1'b0, 3'd0, 0};
    vecs[1]  = '{7'h5F, 2'b00, 20, 12'h006, 1'b1, 3'd6, 1};
    vecs[2]  = '{7'h1F, 2'b00, 20, 12'h006, 1'b1, 3'd6, 0};
    vecs[3]  = '{7'h5D, 2'b00, 20, 12'h002, 1'b1, 3'd2, 1};
    vecs[4]  = '{7'h5F, 2'b00, 20, 12'h006, 1'b1, 3'd6, 1};
    vecs[5]  = '{7'h7F, 2'b00, 20, 12'h000, 1'b0, 3'd0, 0};
    vecs[6]  = '{7'h7E, 2'b01, 20, 12'h010, 1'b1, 3'd1, 1};
    vecs[7]  = '{7'h7E, 2'b10, 20, 12'h010, 1'b1, 3'd1, 0};
    vecs[8]  = '{7'h7F, 2'b10, 20, 12'h000, 1'b0, 3'd0, 0};
    vecs[9]  = '{7'h7E, 2'b10, 20, 12'h100, 1'b1, 3'd1, 1};
    vecs[10] = '{7'h7F, 2'b11, 20, 12'h000, 1'b0, 3'd0, 0};
    vecs[11] = '{7'h6F, 2'b11, 20, 12'h050, 1'b1, 3'd5, 1};
    vecs[12] = '{7'h7F, 2'b11, 20, 12'h000, 1'b0, 3'd0, 0};

    rst = 1'b1;
    key_n = 7'h7F;
    oct_sel = 2'b01;
    repeat (3) @(negedge clk_5MHz);
    checkIdle("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].key, vecs[i].oct, vecs[i].cycles, s, fs, fl, vs);
      checkOutput($sformatf("vec%0d code", i),    int'(note_code),  int'(vecs[i].code));
      checkOutput($sformatf("vec%0d valid", i),   int'(note_valid), int'(vecs[i].valid));
      checkOutput($sformatf("vec%0d idx", i),     int'(key_idx),    int'(vecs[i].idx));
      checkOutput($sformatf("vec%0d strobes", i), s,                vecs[i].strobes);
    end

    applyStimulus(7'h7B, 2'b01, 20, s, fs, fl, vs);
    checkOutput("press latency", fs, DC + 3);
    checkOutput("press strobes", s, 1);
    checkOutput("press code", int'(note_code), 12'h030);
    checkOutput("press idx", int'(key_idx), 3);
    checkOutput("press valid", int'(note_valid), 1);
    applyStimulus(7'h7F, 2'b01, 20, s, fs, fl, vs);
    checkOutput("release latency", fl, DC + 3);
    checkOutput("release strobes", s, 0);
    checkOutput("release code", int'(note_code), 0);

    ts = 0;
    tv = 0;
    for (int t = 0; t < 20; t++) begin
      applyStimulus((t % 2 == 0) ? 7'h6F : 7'h7F, 2'b10, 2, s, fs, fl, vs);
      ts += s;
      tv |= vs;
    end
    checkOutput("chatter strobes", ts, 0);
    checkOutput("chatter valid", tv, 0);
    applyStimulus(7'h6F, 2'b10, 20, s, fs, fl, vs);
    checkOutput("chatter hold code", int'(note_code), 12'h500);
    checkOutput("chatter hold strobes", s, 1);
    applyStimulus(7'h7F, 2'b10, 20, s, fs, fl, vs);
    checkOutput("chatter release valid", int'(note_valid), 0);

    applyStimulus(7'h7B, 2'b01, 4, s, fs, fl, vs);
    checkOutput("arm no strobe", s, 0);
    pulseReset();
    checkIdle("rst in arm");
    applyStimulus(7'h7B, 2'b01, 12, s, fs, fl, vs);
    checkOutput("rearm latency", fs, DC + 3);
    checkOutput("rearm strobes", s, 1);
    checkOutput("rearm code", int'(note_code), 12'h030);
    pulseReset();
    checkIdle("rst in held");
    applyStimulus(7'h7B, 2'b01, 12, s, fs, fl, vs);
    checkOutput("reheld latency", fs, DC + 3);
    checkOutput("reheld strobes", s, 1);
    checkOutput("reheld idx", int'(key_idx), 3);
    applyStimulus(7'h7F, 2'b01, 12, s, fs, fl, vs);
    checkOutput("final release latency", fl, DC + 3);
    checkOutput("final release strobes", s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
